// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared widths, depth defaults and enable levels for the instruction queue.
package inst_queue_pkg;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int ADDRESS_WIDTH = 32;
  localparam int INSTQUEUE_DEPTH = 16;
  localparam int INSTQUEUE_ADDR_W = 4;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular fetch-to-decode instruction buffer with flush and registered decoder handoff.
// Optional sticky overflow flag when INSTQUEUE_OVERFLOW_CHK_EN is defined.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = INSTQUEUE_DEPTH,
  parameter int ADDR_W = INSTQUEUE_ADDR_W
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         ifetch_inst_en_in,
  input  logic [INSTRUCTION_WIDTH-1:0] ifetch_inst_in,
  input  logic [ADDRESS_WIDTH-1:0]     ifetch_pc_in,
  output logic                         ifetch_rdy_out,
  input  logic                         decoder_rdy_in,
  output logic                         decoder_en_out,
  output logic [INSTRUCTION_WIDTH-1:0] decoder_inst_out,
  output logic [ADDRESS_WIDTH-1:0]     decoder_pc_out,
  input  logic                         rob_en_in
`ifdef INSTQUEUE_OVERFLOW_CHK_EN
  , output logic                       overflow_err_out
`endif
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] NEAR_FULL = (ADDR_W+1)'(DEPTH-2);
  logic [INSTRUCTION_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0]     pc_mem   [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              en_q, en_d;
  logic [INSTRUCTION_WIDTH-1:0] inst_q, inst_d;
  logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d;
  logic run, flush, do_push, do_pop;
  always_comb begin
    run = rdy_in && !rob_en_in;
    flush = rdy_in && rob_en_in;
    do_push = run && ifetch_inst_en_in && (count_q != FULL);
    do_pop = run && decoder_rdy_in && (count_q != '0);
    head_d = flush ? '0 : head_q + {{(ADDR_W-1){1'b0}}, do_pop};
    tail_d = flush ? '0 : tail_q + {{(ADDR_W-1){1'b0}}, do_push};
    count_d = flush ? '0 : count_q + {{ADDR_W{1'b0}}, do_push} - {{ADDR_W{1'b0}}, do_pop};
    en_d = do_pop ? ENABLE : DISABLE;
    inst_d = do_pop ? inst_mem[head_q] : inst_q;
    pc_d = do_pop ? pc_mem[head_q] : pc_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      en_q <= DISABLE;
      inst_q <= '0;
      pc_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      en_q <= en_d;
      inst_q <= inst_d;
      pc_q <= pc_d;
    end
  end
  // storage array is deliberately left out of reset
  always_ff @(posedge clk_in) begin
    if (!rst_in && do_push) begin
      inst_mem[tail_q] <= ifetch_inst_in;
      pc_mem[tail_q] <= ifetch_pc_in;
    end
  end
  assign ifetch_rdy_out = count_q <= NEAR_FULL;
  assign decoder_en_out = en_q;
  assign decoder_inst_out = inst_q;
  assign decoder_pc_out = pc_q;
`ifdef INSTQUEUE_OVERFLOW_CHK_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = ovf_q | (run && ifetch_inst_en_in && (count_q == FULL));
  always_ff @(posedge clk_in) begin
    if (rst_in) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign overflow_err_out = ovf_q;
`endif
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed self-checking bench for inst_queue (overflow checks under INSTQUEUE_OVERFLOW_CHK_EN).
module tb_inst_queue;
  logic clk = 1'b0;
  logic rst = 1'b0, rdy = 1'b1, fen = 1'b0, drdy = 1'b0, rob = 1'b0;
  logic [31:0] finst = '0, fpc = '0;
  logic frdy, den;
  logic [31:0] dinst, dpc;
`ifdef INSTQUEUE_OVERFLOW_CHK_EN
  logic ovf;
`endif
  int checks = 0, failures = 0;
  inst_queue dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .ifetch_inst_en_in(fen), .ifetch_inst_in(finst), .ifetch_pc_in(fpc),
    .ifetch_rdy_out(frdy), .decoder_rdy_in(drdy), .decoder_en_out(den),
    .decoder_inst_out(dinst), .decoder_pc_out(dpc), .rob_en_in(rob)
`ifdef INSTQUEUE_OVERFLOW_CHK_EN
    , .overflow_err_out(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] pc);
    fen = 1'b1;
    fpc = pc;
    finst = pc ^ 32'hA5A5_0000;
    tick();
    fen = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", den); end
    checks++; if (dinst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", dinst); end
    checks++; if (dpc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", dpc); end
    checks++; if (frdy !== 1'b1) begin failures++; $display("FAIL reset_frdy got=%b exp=1", frdy); end
`ifdef INSTQUEUE_OVERFLOW_CHK_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
  endtask
  task automatic test_single();
    drdy = 1'b1;
    fen = 1'b1; fpc = 32'h0; finst = 32'h0000_0013;
    tick();
    fen = 1'b0;
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", den); end
    tick();
    checks++; if (den !== 1'b1) begin failures++; $display("FAIL single_en got=%b exp=1", den); end
    checks++; if (dpc !== 32'h0) begin failures++; $display("FAIL single_pc got=%h exp=0", dpc); end
    checks++; if (dinst !== 32'h0000_0013) begin failures++; $display("FAIL single_inst got=%h exp=00000013", dinst); end
    tick();
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL single_one_pulse got=%b exp=0", den); end
    drdy = 1'b0;
  endtask
  task automatic test_fill_overflow();
    for (int i = 0; i < 14; i++) push(32'h100 + 32'(4*i));
    checks++; if (frdy !== 1'b1) begin failures++; $display("FAIL fill_frdy14 got=%b exp=1", frdy); end
    push(32'h100 + 32'(4*14));
    checks++; if (frdy !== 1'b0) begin failures++; $display("FAIL fill_frdy15 got=%b exp=0", frdy); end
    push(32'h100 + 32'(4*15));
`ifdef INSTQUEUE_OVERFLOW_CHK_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fill_ovf16 got=%b exp=0", ovf); end
`endif
    push(32'hDEAD_0000);
`ifdef INSTQUEUE_OVERFLOW_CHK_EN
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL fill_ovf17 got=%b exp=1", ovf); end
`endif
    drdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (den !== 1'b1 || dpc !== 32'h100 + 32'(4*i) || dinst !== ((32'h100 + 32'(4*i)) ^ 32'hA5A5_0000)) begin
        failures++; $display("FAIL fill_drain[%0d] got en=%b pc=%h inst=%h exp pc=%h", i, den, dpc, dinst, 32'h100 + 32'(4*i));
      end
    end
    tick();
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL fill_dropped_absent got=%b exp=0", den); end
    drdy = 1'b0;
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 10; i++) push(32'h200 + 32'(4*i));
    drdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (den !== 1'b1 || dpc !== 32'h200 + 32'(4*i)) begin failures++; $display("FAIL wrap_drain8[%0d] got en=%b pc=%h", i, den, dpc); end
    end
    drdy = 1'b0;
    tick();
    for (int i = 10; i < 22; i++) push(32'h200 + 32'(4*i));
    checks++; if (frdy !== 1'b1) begin failures++; $display("FAIL wrap_frdy14 got=%b exp=1", frdy); end
    drdy = 1'b1;
    for (int i = 8; i < 22; i++) begin
      tick();
      checks++; if (den !== 1'b1 || dpc !== 32'h200 + 32'(4*i)) begin failures++; $display("FAIL wrap_pop[%0d] got en=%b pc=%h exp=%h", i, den, dpc, 32'h200 + 32'(4*i)); end
    end
    tick();
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b exp=0", den); end
    drdy = 1'b0;
  endtask
  task automatic test_simul();
    for (int i = 0; i < 5; i++) push(32'h300 + 32'(4*i));
    drdy = 1'b1;
    push(32'h314);
    checks++; if (den !== 1'b1 || dpc !== 32'h300) begin failures++; $display("FAIL simul_oldest got en=%b pc=%h exp=00000300", den, dpc); end
    for (int i = 1; i < 6; i++) begin
      tick();
      checks++; if (den !== 1'b1 || dpc !== 32'h300 + 32'(4*i)) begin failures++; $display("FAIL simul_pop[%0d] got en=%b pc=%h", i, den, dpc); end
    end
    tick();
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL simul_count5 got=%b exp=0", den); end
    drdy = 1'b0;
  endtask
  task automatic test_flush();
    for (int i = 0; i < 7; i++) push(32'h400 + 32'(4*i));
    rob = 1'b1; drdy = 1'b1;
    push(32'h500);
    rob = 1'b0;
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL flush_en got=%b exp=0", den); end
    checks++; if (frdy !== 1'b1) begin failures++; $display("FAIL flush_frdy got=%b exp=1", frdy); end
    tick();
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", den); end
    push(32'h600);
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL flush_nobypass got=%b exp=0", den); end
    tick();
    checks++; if (den !== 1'b1 || dpc !== 32'h600) begin failures++; $display("FAIL flush_newpop got en=%b pc=%h exp=00000600", den, dpc); end
`ifdef INSTQUEUE_OVERFLOW_CHK_EN
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL flush_ovf_sticky got=%b exp=1", ovf); end
`endif
    drdy = 1'b0;
    tick();
  endtask
  task automatic test_hold();
    for (int i = 0; i < 3; i++) push(32'h700 + 32'(4*i));
    drdy = 1'b1; rdy = 1'b0; fen = 1'b1; fpc = 32'h7FF;
    for (int i = 0; i < 4; i++) begin
      rob = (i == 2);
      tick();
      checks++; if (den !== 1'b0 || dpc !== 32'h600) begin failures++; $display("FAIL hold[%0d] got en=%b pc=%h exp en=0 pc=00000600", i, den, dpc); end
    end
    rob = 1'b0; fen = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (den !== 1'b1 || dpc !== 32'h700 + 32'(4*i)) begin failures++; $display("FAIL hold_resume[%0d] got en=%b pc=%h", i, den, dpc); end
    end
    tick();
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL hold_empty got=%b exp=0", den); end
    drdy = 1'b0;
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) push(32'h800 + 32'(4*i));
    checks++; if (frdy !== 1'b0) begin failures++; $display("FAIL rmid_full got=%b exp=0", frdy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (frdy !== 1'b1 || den !== 1'b0 || dpc !== 32'h0) begin failures++; $display("FAIL rmid_state got frdy=%b en=%b pc=%h", frdy, den, dpc); end
`ifdef INSTQUEUE_OVERFLOW_CHK_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rmid_ovf got=%b exp=0", ovf); end
`endif
    drdy = 1'b1;
    tick();
    checks++; if (den !== 1'b0) begin failures++; $display("FAIL rmid_empty got=%b exp=0", den); end
    drdy = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_wrap();
    test_simul();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
